// File: rtl/sdram_log_writer.sv
// Packs timestamped samples into 3-word records, buffers them and writes them to
// SDRAM one word per command. Define SDRAM_LOG_WRAP_EN to wrap the write pointer.
module sdram_log_writer #(
  parameter int unsigned FIFO_DEPTH  = 16,
  parameter int unsigned ACK_TIMEOUT = 15,
  parameter logic [23:0] START_ADDR  = 24'h000000,
  parameter logic [7:0]  SYNC_BYTE   = 8'hA5
) (
  input  logic                            CLK_48MHZ,
  input  logic                            RESET,
  input  logic [23:0]                     TIMESTAMP,
  input  logic [15:0]                     SAMPLE_DATA,
  input  logic                            SAMPLE_VALID,
  output logic                            SAMPLE_READY,
  input  logic                            SDRAM_STATUS,
  output logic [1:0]                      CMD_IN,
  output logic [1:0]                      A_IN_BANK,
  output logic [12:0]                     A_IN_ROW,
  output logic [8:0]                      A_IN_COL,
  output logic [15:0]                     D_IN,
  output logic [23:0]                     WR_ADDR,
  output logic [$clog2(FIFO_DEPTH):0]     FIFO_LEVEL,
  output logic                            OVERFLOW,
  output logic                            MEM_FULL
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;
  localparam int unsigned TMO_W = $clog2(ACK_TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ISSUE, S_WAIT_ACK, S_WAIT_DONE, S_ADVANCE
  } state_e;

  state_e            state_q, state_d;
  logic              alive_q, alive_d;
  logic [1:0]        stage_cnt_q, stage_cnt_d;
  logic [23:0]       stage_ts_q, stage_ts_d;
  logic [15:0]       stage_data_q, stage_data_d;
  logic [15:0]       fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]  level_q, level_d;
  logic              overflow_q, overflow_d;
  logic              mem_full_q, mem_full_d;
  logic [23:0]       wr_addr_q, wr_addr_d;
  logic [15:0]       d_in_q, d_in_d;
  logic [TMO_W-1:0]  tmo_cnt_q, tmo_cnt_d;

  logic              sample_ready, accept, push, pop, cmd_write;
  logic [15:0]       push_word;
  logic [LVL_W-1:0]  free_words;

  // alive_q keeps SAMPLE_READY low for the first cycle after reset is released.
  assign free_words   = LVL_W'(FIFO_DEPTH) - level_q;
  assign sample_ready = alive_q && (stage_cnt_q == 2'd0) &&
                        (free_words >= LVL_W'(3)) && !mem_full_q;
  assign accept       = SAMPLE_VALID && sample_ready;

  // NOTE: every variable written here gets a default first so no latch is inferred.
  always_comb begin
    alive_d      = 1'b1;
    stage_cnt_d  = stage_cnt_q;
    stage_ts_d   = stage_ts_q;
    stage_data_d = stage_data_q;
    push         = 1'b0;
    push_word    = '0;
    if (accept) begin
      stage_cnt_d  = 2'd3;
      stage_ts_d   = TIMESTAMP;
      stage_data_d = SAMPLE_DATA;
    end else if (stage_cnt_q != 2'd0) begin
      push        = 1'b1;
      stage_cnt_d = stage_cnt_q - 2'd1;
      case (stage_cnt_q)
        2'd3:    push_word = {SYNC_BYTE, stage_ts_q[23:16]};
        2'd2:    push_word = stage_ts_q[15:0];
        default: push_word = stage_data_q;
      endcase
    end
  end

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    case ({push, pop})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase
    overflow_d = overflow_q | (SAMPLE_VALID & ~sample_ready);
  end

  // Write FSM: next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:      if (level_q != '0 && !SDRAM_STATUS && !mem_full_q) state_d = S_ISSUE;
      S_ISSUE:     state_d = S_WAIT_ACK;
      S_WAIT_ACK: begin
        if (SDRAM_STATUS)                               state_d = S_WAIT_DONE;
        else if (tmo_cnt_q == TMO_W'(ACK_TIMEOUT - 1))  state_d = S_ISSUE;
      end
      S_WAIT_DONE: if (!SDRAM_STATUS) state_d = S_ADVANCE;
      S_ADVANCE:   state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase
  end

  // Write FSM: outputs and the datapath they steer.
  always_comb begin
    cmd_write  = (state_q == S_ISSUE);
    pop        = (state_q == S_ADVANCE);
    tmo_cnt_d  = (state_q == S_WAIT_ACK) ? tmo_cnt_q + TMO_W'(1) : '0;
    d_in_d     = (state_d == S_ISSUE) ? fifo_mem[rd_ptr_q] : d_in_q;
    wr_addr_d  = wr_addr_q;
    mem_full_d = mem_full_q;
`ifdef SDRAM_LOG_WRAP_EN
    if (pop) wr_addr_d = wr_addr_q + 24'd1;
    mem_full_d = 1'b0;
`else
    if (pop) begin
      if (wr_addr_q == 24'hFFFFFF) mem_full_d = 1'b1;
      else                         wr_addr_d  = wr_addr_q + 24'd1;
    end
`endif
  end

  // NOTE: the FIFO storage has no reset; only the pointers and level define its contents.
  always_ff @(posedge CLK_48MHZ) begin
    if (push) fifo_mem[wr_ptr_q] <= push_word;
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge CLK_48MHZ) begin
    if (RESET) begin
      state_q      <= S_IDLE;
      alive_q      <= 1'b0;
      stage_cnt_q  <= 2'd0;
      stage_ts_q   <= '0;
      stage_data_q <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      level_q      <= '0;
      overflow_q   <= 1'b0;
      mem_full_q   <= 1'b0;
      wr_addr_q    <= START_ADDR;
      d_in_q       <= '0;
      tmo_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      alive_q      <= alive_d;
      stage_cnt_q  <= stage_cnt_d;
      stage_ts_q   <= stage_ts_d;
      stage_data_q <= stage_data_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      level_q      <= level_d;
      overflow_q   <= overflow_d;
      mem_full_q   <= mem_full_d;
      wr_addr_q    <= wr_addr_d;
      d_in_q       <= d_in_d;
      tmo_cnt_q    <= tmo_cnt_d;
    end
  end

  assign SAMPLE_READY = sample_ready;
  assign CMD_IN       = cmd_write ? 2'b01 : 2'b00;
  assign A_IN_BANK    = wr_addr_q[23:22];
  assign A_IN_ROW     = wr_addr_q[21:9];
  assign A_IN_COL     = wr_addr_q[8:0];
  assign D_IN         = d_in_q;
  assign WR_ADDR      = wr_addr_q;
  assign FIFO_LEVEL   = level_q;
  assign OVERFLOW     = overflow_q;
  assign MEM_FULL     = mem_full_q;

endmodule

// File: doc/sdram_log_writer.md
Name: sdram_log_writer

Overview:
- Upstream feeder for sdram_interface, clocked on the same 48 MHz domain.
- Accepts timestamped 16-bit samples and packs each one into a 3-word record.
- Buffers record words in a word FIFO, then streams them into SDRAM as single-word write commands at a linearly incrementing address.
- Owns the CMD_IN / STATUS handshake, so acquisition logic never touches SDRAM addressing.

Parameters:
- FIFO_DEPTH, 16: FIFO size in 16-bit words; power of two, at least 4.
- ACK_TIMEOUT, 15: cycles to wait for SDRAM_STATUS to rise after a command before re-issuing it.
- START_ADDR, 24'h000000: write pointer value after reset.
- SYNC_BYTE, 8'hA5: marker byte placed in the first word of every record.

Ports:
- CLK_48MHZ  in  1  system clock; all logic on rising edge.
- RESET  in  1  synchronous, active-high reset.
- TIMESTAMP  in  24  free-running timestamp, sampled when a sample is accepted.
- SAMPLE_DATA  in  16  sample payload.
- SAMPLE_VALID  in  1  sample offered this cycle.
- SAMPLE_READY  out  1  sample accepted when VALID and READY are both high.
- SDRAM_STATUS  in  1  sdram_interface busy flag; 1 = command in progress.
- CMD_IN  out  2  command to sdram_interface: 00 NOP, 01 WRITE; 10 and 11 are never driven.
- A_IN_BANK  out  2  bank address, equal to WR_ADDR[23:22].
- A_IN_ROW  out  13  row address, equal to WR_ADDR[21:9].
- A_IN_COL  out  9  column address, equal to WR_ADDR[8:0].
- D_IN  out  16  write data word.
- WR_ADDR  out  24  current SDRAM word pointer.
- FIFO_LEVEL  out  log2(FIFO_DEPTH)+1  FIFO occupancy in words.
- OVERFLOW  out  1  sticky; a sample was offered while SAMPLE_READY was low.
- MEM_FULL  out  1  write pointer has exhausted memory (non-wrap build only).

Behaviour:
- Reset values: CMD_IN=00, D_IN=0, WR_ADDR=START_ADDR, FIFO empty, FIFO_LEVEL=0, OVERFLOW=0, MEM_FULL=0, SAMPLE_READY=0, FSM in IDLE.
  - SAMPLE_READY first goes high the cycle after RESET deasserts.
- Record format, one accepted sample produces three words in this order:
  - W0 = {SYNC_BYTE, TIMESTAMP[23:16]}
  - W1 = TIMESTAMP[15:0]
  - W2 = SAMPLE_DATA
- Capture:
  - On acceptance, TIMESTAMP and SAMPLE_DATA are latched into a staging register.
  - The stager pushes one word per cycle on the next 3 cycles.
- SAMPLE_READY = stager idle AND FIFO free words ≥ 3 AND MEM_FULL=0.
- VALID while READY=0: the sample is dropped and OVERFLOW sets. OVERFLOW clears only on RESET.
- FIFO push and pop in the same cycle is legal; FIFO_LEVEL is unchanged in that case.
- Write FSM:
  - IDLE: if FIFO non-empty, SDRAM_STATUS=0 and MEM_FULL=0, go to ISSUE.
  - ISSUE: for exactly one cycle drive CMD_IN=01, D_IN=FIFO head and A_IN_*=WR_ADDR fields, then go to WAIT_ACK. CMD_IN is 00 in every other state.
  - WAIT_ACK: on SDRAM_STATUS=1 go to WAIT_DONE. After ACK_TIMEOUT cycles with no ack, go back to ISSUE with the same word and address.
  - WAIT_DONE: on SDRAM_STATUS=0 go to ADVANCE.
  - ADVANCE: pop the FIFO head and set WR_ADDR = WR_ADDR+1, then go to IDLE.
- Address and data outputs hold their values through WAIT_ACK and WAIT_DONE.
- Minimum cost is 5 cycles per word plus sdram_interface busy time.
- Pointer end: when WR_ADDR=24'hFFFFFF and ADVANCE occurs, behaviour follows the Optional Feature.
- RESET in any state: FSM returns to IDLE and FIFO contents are discarded. An in-flight command is abandoned; CMD_IN is 00 from the next cycle.

Optional Feature:
- Macro: SDRAM_LOG_WRAP_EN.
- Defined: WR_ADDR wraps from 24'hFFFFFF to 24'h000000 and logging continues; MEM_FULL is tied 0.
- Undefined:
  - ADVANCE at 24'hFFFFFF sets MEM_FULL (sticky until RESET) and WR_ADDR holds at 24'hFFFFFF.
  - The FSM stays in IDLE and SAMPLE_READY stays 0.
  - Words already in the FIFO are retained but not written.

Test Plan:
- Single record: reset, TIMESTAMP=24'h123456, one sample 16'h0001 with SDRAM_STATUS modelled as 3 busy cycles per command -> three CMD_IN=01 pulses with D_IN=16'hA512, 16'h3456, 16'h0001 at WR_ADDR 0,1,2; WR_ADDR ends at 3.
- Address split: START_ADDR=24'h7FC1FE -> first write drives A_IN_BANK=01, A_IN_ROW=13'h1FE0, A_IN_COL=9'h1FE.
- Backpressure: hold SDRAM_STATUS=1 and offer 6 samples back-to-back with FIFO_DEPTH=16 -> 5 accepted (FIFO_LEVEL=15), SAMPLE_READY low, 6th sample dropped, OVERFLOW=1.
- Ack timeout: SDRAM_STATUS never rises for the first command -> CMD_IN=01 re-pulsed exactly ACK_TIMEOUT+1 cycles after the first pulse, same address and data; WR_ADDR unchanged until ack arrives.
- Pointer end: START_ADDR=24'hFFFFFE, two samples -> with SDRAM_LOG_WRAP_EN, writes land at FFFFFE, FFFFFF, 000000, 000001, ...; without it, MEM_FULL=1 after the second write and no further CMD_IN=01.
- Mid-operation reset: assert RESET during WAIT_DONE with FIFO_LEVEL=4 -> next cycle CMD_IN=00, FIFO_LEVEL=0, WR_ADDR=START_ADDR, OVERFLOW=0.
